// File: rtl/hdmi_period_sched.sv
// ============================================================================
// Module  : hdmi_period_sched
// Purpose : Sequences HDMI TX link periods (control, video preamble, video
//           leading guard band, video data) ahead of the TMDS encoders.
//           The pixel/sync stream is delayed so the preamble and guard band
//           fit in front of every active line; lines whose blanking is too
//           short to hold the minimum control period are dropped.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module hdmi_period_sched #(
  parameter int PX_WIDTH     = 8,
  parameter int PREAMBLE_LEN = 8,
  parameter int GB_LEN       = 2,
  parameter int MIN_CTL_LEN  = 12
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                de_i,
  input  logic                hsync_i,
  input  logic                vsync_i,
  input  logic [PX_WIDTH-1:0] red_i,
  input  logic [PX_WIDTH-1:0] green_i,
  input  logic [PX_WIDTH-1:0] blue_i,
  output logic                de_o,
  output logic                hsync_o,
  output logic                vsync_o,
  output logic                preamble_o,
  output logic                gb_o,
  output logic [3:0]          ctl_o,
  output logic [PX_WIDTH-1:0] red_o,
  output logic [PX_WIDTH-1:0] green_o,
  output logic [PX_WIDTH-1:0] blue_o,
  output logic                blank_err_o
);

  // Insertion depth, pipeline length and required blanking.
  localparam int D         = PREAMBLE_LEN + GB_LEN;
  localparam int L         = D + 1;
  localparam int MIN_BLANK = MIN_CTL_LEN + D;
  localparam int CW        = $clog2(MIN_BLANK + 1);
  localparam int PCW       = $clog2(D + 1);
  localparam int DW        = 3 + 3 * PX_WIDTH;

  typedef enum logic [1:0] {
    ST_CTL = 2'd0,
    ST_PRE = 2'd1,
    ST_GB  = 2'd2,
    ST_VID = 2'd3
  } state_e;

  logic            de_prev_q;
  logic [CW-1:0]   blank_cnt_q;
  logic            start_q;
  logic            rej_q;
  logic [DW-1:0]   dl_q [L];
  state_e          state_q;
  logic [PCW-1:0]  phase_q;

  logic            rise_w;
  logic            blank_ok_w;
  logic            t_de_w;
  logic            t_hs_w;
  logic            t_vs_w;
  logic [PX_WIDTH-1:0] t_r_w;
  logic [PX_WIDTH-1:0] t_g_w;
  logic [PX_WIDTH-1:0] t_b_w;

  assign rise_w     = de_i & ~de_prev_q;
  assign blank_ok_w = (blank_cnt_q >= CW'(MIN_BLANK));

  // Oldest entry of the delay line, split back into its fields.
  assign {t_de_w, t_hs_w, t_vs_w, t_r_w, t_g_w, t_b_w} = dl_q[L-1];

  // Input side: blanking length measurement and rise classification.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      de_prev_q   <= 1'b0;
      blank_cnt_q <= '0;
      start_q     <= 1'b0;
      rej_q       <= 1'b0;
    end else begin
      de_prev_q <= de_i;
      if (de_i)
        blank_cnt_q <= '0;
      else if (!blank_ok_w)
        blank_cnt_q <= blank_cnt_q + 1'b1;
      start_q <= rise_w & blank_ok_w;
      rej_q   <= rise_w & ~blank_ok_w;
    end
  end

  // Delay line that makes room for the preamble and guard band.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < L; i++) dl_q[i] <= '0;
    end else begin
      dl_q[0] <= {de_i, hsync_i, vsync_i, red_i, green_i, blue_i};
      for (int i = 1; i < L; i++) dl_q[i] <= dl_q[i-1];
    end
  end

  // Output-side period FSM with registered outputs. A dropped line never
  // leaves CTL, so its delayed pixels are masked without extra state.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_CTL;
      phase_q     <= '0;
      de_o        <= 1'b0;
      hsync_o     <= 1'b0;
      vsync_o     <= 1'b0;
      preamble_o  <= 1'b0;
      gb_o        <= 1'b0;
      ctl_o       <= 4'b0000;
      red_o       <= '0;
      green_o     <= '0;
      blue_o      <= '0;
      blank_err_o <= 1'b0;
    end else begin
      hsync_o     <= t_hs_w;
      vsync_o     <= t_vs_w;
      blank_err_o <= rej_q;
      de_o        <= 1'b0;
      preamble_o  <= 1'b0;
      gb_o        <= 1'b0;
      ctl_o       <= 4'b0000;
      red_o       <= '0;
      green_o     <= '0;
      blue_o      <= '0;
      case (state_q)
        ST_CTL: begin
          if (start_q) begin
            state_q    <= ST_PRE;
            phase_q    <= '0;
            preamble_o <= 1'b1;
            ctl_o      <= 4'b0001;
          end
        end
        ST_PRE: begin
          if (phase_q == PCW'(PREAMBLE_LEN - 1)) begin
            state_q <= ST_GB;
            phase_q <= '0;
            gb_o    <= 1'b1;
          end else begin
            phase_q    <= phase_q + 1'b1;
            preamble_o <= 1'b1;
            ctl_o      <= 4'b0001;
          end
        end
        ST_GB: begin
          if (phase_q == PCW'(GB_LEN - 1)) begin
            phase_q <= '0;
            if (t_de_w) begin
              state_q <= ST_VID;
              de_o    <= 1'b1;
              red_o   <= t_r_w;
              green_o <= t_g_w;
              blue_o  <= t_b_w;
            end else begin
              state_q <= ST_CTL;
            end
          end else begin
            phase_q <= phase_q + 1'b1;
            gb_o    <= 1'b1;
          end
        end
        default: begin
          if (t_de_w) begin
            de_o    <= 1'b1;
            red_o   <= t_r_w;
            green_o <= t_g_w;
            blue_o  <= t_b_w;
          end else begin
            state_q <= ST_CTL;
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hdmi_period_sched.sv
// ============================================================================
// Module  : tb_hdmi_period_sched
// Purpose : Self-checking bench for hdmi_period_sched. A history-based model
//           derives every output cycle from the input record (rise edges,
//           blanking run lengths, fixed latency) and a compare process checks
//           the DUT each cycle; per-group literal period counts pin the model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hdmi_period_sched;

  localparam int PXW     = 8;
  localparam int LAT     = 11;
  localparam int PRE_LEN = 8;
  localparam int GBL     = 2;
  localparam int MINB    = 22;
  localparam int MAXN    = 1024;

  logic           clk_i = 1'b0;
  logic           rst_n_i;
  logic           de_i, hsync_i, vsync_i;
  logic [PXW-1:0] red_i, green_i, blue_i;
  logic           de_o, hsync_o, vsync_o, preamble_o, gb_o, blank_err_o;
  logic [3:0]     ctl_o;
  logic [PXW-1:0] red_o, green_o, blue_o;

  always #5 clk_i = ~clk_i;

  hdmi_period_sched #(
    .PX_WIDTH(PXW), .PREAMBLE_LEN(PRE_LEN), .GB_LEN(GBL), .MIN_CTL_LEN(12)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .de_i(de_i), .hsync_i(hsync_i), .vsync_i(vsync_i),
    .red_i(red_i), .green_i(green_i), .blue_i(blue_i),
    .de_o(de_o), .hsync_o(hsync_o), .vsync_o(vsync_o),
    .preamble_o(preamble_o), .gb_o(gb_o), .ctl_o(ctl_o),
    .red_o(red_o), .green_o(green_o), .blue_o(blue_o),
    .blank_err_o(blank_err_o)
  );

  // Input history since the last reset release, indexed by sampling edge.
  bit             s_de [MAXN];
  bit             s_hs [MAXN];
  bit             s_vs [MAXN];
  logic [PXW-1:0] s_r  [MAXN];
  logic [PXW-1:0] s_g  [MAXN];
  logic [PXW-1:0] s_b  [MAXN];
  bit             acc  [MAXN];
  bit             rej  [MAXN];

  int n;
  bit run;
  int cmp_cnt;
  int err_cnt;
  int c_pre, c_gb, c_de, c_err;

  task automatic chk(input string nm, input int cyc, input logic [63:0] act, input logic [63:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic int lows_before(input int k);
    int c = 0;
    for (int j = k - 1; j >= 0 && c < MINB; j--) begin
      if (s_de[j]) break;
      c++;
    end
    return c;
  endfunction

  function automatic bit exp_pre(input int k);
    for (int j = k - PRE_LEN; j <= k - 1; j++)
      if (j >= 0 && acc[j]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit exp_gb(input int k);
    for (int j = k - PRE_LEN - GBL; j <= k - PRE_LEN - 1; j++)
      if (j >= 0 && acc[j]) return 1'b1;
    return 1'b0;
  endfunction

  // Delayed sample belongs to video only if the line it is part of was accepted.
  function automatic bit exp_de(input int k);
    int m = k - LAT;
    int j;
    if (m < 0 || !s_de[m]) return 1'b0;
    j = m;
    while (j > 0 && s_de[j-1]) j--;
    return acc[j];
  endfunction

  // Compare process: records the sample at each edge, checks outputs 1 ns later.
  initial begin
    forever begin
      @(posedge clk_i);
      if (run && n < MAXN) begin
        bit r, e_de, e_pre, e_gb, e_hs, e_vs, e_err;
        logic [PXW-1:0] e_r, e_g, e_b;
        s_de[n] = de_i; s_hs[n] = hsync_i; s_vs[n] = vsync_i;
        s_r[n] = red_i; s_g[n] = green_i; s_b[n] = blue_i;
        r = de_i && (n == 0 || !s_de[n-1]);
        acc[n] = r && (lows_before(n) >= MINB);
        rej[n] = r && (lows_before(n) < MINB);
        #1;
        e_de  = exp_de(n);
        e_pre = exp_pre(n);
        e_gb  = exp_gb(n);
        e_hs  = (n >= LAT) ? s_hs[n-LAT] : 1'b0;
        e_vs  = (n >= LAT) ? s_vs[n-LAT] : 1'b0;
        e_err = (n >= 1) ? rej[n-1] : 1'b0;
        e_r   = e_de ? s_r[n-LAT] : '0;
        e_g   = e_de ? s_g[n-LAT] : '0;
        e_b   = e_de ? s_b[n-LAT] : '0;
        chk("de_o",        n, 64'(de_o),        64'(e_de));
        chk("preamble_o",  n, 64'(preamble_o),  64'(e_pre));
        chk("gb_o",        n, 64'(gb_o),        64'(e_gb));
        chk("ctl_o",       n, 64'(ctl_o),       e_pre ? 64'd1 : 64'd0);
        chk("hsync_o",     n, 64'(hsync_o),     64'(e_hs));
        chk("vsync_o",     n, 64'(vsync_o),     64'(e_vs));
        chk("blank_err_o", n, 64'(blank_err_o), 64'(e_err));
        chk("rgb_o",       n, {40'd0, red_o, green_o, blue_o}, {40'd0, e_r, e_g, e_b});
        c_pre += int'(preamble_o);
        c_gb  += int'(gb_o);
        c_de  += int'(de_o);
        c_err += int'(blank_err_o);
        n++;
      end
    end
  end

  task automatic drive(input bit de, input int cycles);
    repeat (cycles) begin
      @(negedge clk_i);
      de_i    = de;
      hsync_i = 1'($urandom);
      vsync_i = 1'($urandom);
      red_i   = PXW'($urandom);
      green_i = PXW'($urandom);
      blue_i  = PXW'($urandom);
    end
  endtask

  // Hand-counted period totals for one group of lines.
  task automatic group(input string nm, input int pre, input int gb, input int de, input int er);
    @(negedge clk_i);
    chk({nm, "_pre_cnt"}, n, 64'(c_pre), 64'(pre));
    chk({nm, "_gb_cnt"},  n, 64'(c_gb),  64'(gb));
    chk({nm, "_de_cnt"},  n, 64'(c_de),  64'(de));
    chk({nm, "_err_cnt"}, n, 64'(c_err), 64'(er));
    c_pre = 0; c_gb = 0; c_de = 0; c_err = 0;
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_flags"}, n, {58'd0, de_o, hsync_o, vsync_o, preamble_o, gb_o, blank_err_o}, 64'd0);
    chk({nm, "_ctl"},   n, 64'(ctl_o), 64'd0);
    chk({nm, "_rgb"},   n, {40'd0, red_o, green_o, blue_o}, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cmp_cnt = 0; err_cnt = 0; n = 0; run = 1'b0;
    c_pre = 0; c_gb = 0; c_de = 0; c_err = 0;
    rst_n_i = 1'b0;
    de_i = 1'b0; hsync_i = 1'b0; vsync_i = 1'b0;
    red_i = '0; green_i = '0; blue_i = '0;
    repeat (3) @(negedge clk_i);
    check_all_zero("reset");
    rst_n_i = 1'b1; n = 0; run = 1'b1;

    // Nominal 16-pixel line after ample blanking; sync toggles randomly throughout.
    drive(0, 40); drive(1, 16); drive(0, 40);
    group("g1_nominal", 8, 2, 16, 0);
    // Accepted line, then a line after only 15 blanking clocks is dropped.
    drive(1, 8); drive(0, 15); drive(1, 10); drive(0, 40);
    group("g2_short15", 8, 2, 8, 1);
    // Exactly the minimum blanking: both lines sequenced.
    drive(1, 8); drive(0, 22); drive(1, 5); drive(0, 40);
    group("g3_blank22", 16, 4, 13, 0);
    // One clock short of the minimum: second line dropped.
    drive(1, 8); drive(0, 21); drive(1, 5); drive(0, 40);
    group("g4_blank21", 8, 2, 8, 1);

    // Reset asserted while the preamble is running.
    drive(0, 30); drive(1, 1); drive(0, 4);
    chk("g5_in_pre", n, 64'(preamble_o), 64'd1);
    chk("g5_pre_before_rst", n, 64'(c_pre), 64'd3);
    #2;
    run = 1'b0;
    rst_n_i = 1'b0;
    #1;
    check_all_zero("g5_async_rst");
    c_pre = 0; c_gb = 0; c_de = 0; c_err = 0;
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1; n = 0; run = 1'b1;
    drive(0, 22); drive(1, 8); drive(0, 40);
    group("g5_after_rst", 8, 2, 8, 0);

    // Two 1-pixel lines separated by minimum blanking.
    drive(1, 1); drive(0, 22); drive(1, 1); drive(0, 40);
    group("g6_one_pixel", 16, 4, 2, 0);

    run = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

`default_nettype wire
